bist_ctrl: RTL and testbench
============================

BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 16, SHALL set the number of BILBO flops in the controlled scan chain (2 to 64).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the run-length counter and of num_cycles.
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL be the one-cycle request to begin a self-test; it is sampled only in IDLE.
REQ-006 abort  input  1  SHALL be the request to terminate a test in progress.
REQ-007 seed  input  CHAIN_LEN  SHALL be the pattern shifted into the chain; bit 0 shifts first.
REQ-008 golden  input  CHAIN_LEN  SHALL be the expected signature.
REQ-009 num_cycles  input  CNT_W  SHALL be the number of MISR-mode cycles to run.
REQ-010 scan_out  input  1  SHALL be the serial output of the last chain flop.
REQ-011 b1, b2  output  1 each  SHALL be the BILBO mode controls; b2 is driven raw, and the OR(b2, NOT b1) term stays external.
REQ-012 sel  output  1  SHALL be the boundary bypass-mux select: 0 for functional data, 1 for test data.
REQ-013 scan_in  output  1  SHALL be the serial data driven into the first chain flop.
REQ-014 busy, done, pass  output  1 each  SHALL report test in progress, a one-cycle completion pulse, and the comparison result.
REQ-015 signature  output  CHAIN_LEN  SHALL be the captured unload data.

Function
REQ-016 The FSM SHALL have five states: IDLE, SEED, RUN, UNLOAD and DONE, and its outputs SHALL be Moore-decoded from the state.
REQ-017 Mode encodings SHALL be: NORMAL is b1=1, b2=0; SHIFT is b1=0, b2=1; MISR is b1=1, b2=1.
REQ-018 IDLE SHALL drive NORMAL mode with sel=0, scan_in=0 and busy=0; every other state SHALL drive sel=1 and busy=1.
REQ-019 In IDLE, start=1 SHALL latch seed, golden and num_cycles and move the FSM to SEED on the next edge.
REQ-020 SEED SHALL drive SHIFT mode for exactly CHAIN_LEN cycles, with scan_in equal to latched seed[k] in the k-th cycle (k=0..CHAIN_LEN-1).
REQ-021 RUN SHALL drive MISR mode with scan_in=0 for exactly num_cycles cycles; if num_cycles=0, the FSM SHALL go directly from SEED to UNLOAD.
REQ-022 UNLOAD SHALL drive SHIFT mode with scan_in=0 for exactly CHAIN_LEN cycles.
REQ-023 In each UNLOAD cycle, the edge SHALL update signature to {scan_out, signature[CHAIN_LEN-1:1]}, so the first bit unloaded ends in signature[0].
REQ-024 The final UNLOAD edge SHALL enter DONE and SHALL register pass = (updated signature == latched golden).
REQ-025 DONE SHALL last one cycle with done=1 and NORMAL mode, then return to IDLE.
REQ-026 pass and signature SHALL hold their values until the next accepted start, which clears both.
REQ-027 A start asserted while busy=1 SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse and with pass cleared; abort SHALL take priority over every other transition.
REQ-029 The phase counter SHALL be CNT_W-wide unsigned, SHALL reload at each phase entry, and SHALL never wrap within a phase.
REQ-030 Changes to seed, golden or num_cycles during a test SHALL NOT affect that test.

Reset
REQ-031 On rst=1 the block SHALL enter IDLE with b1=1, b2=0, sel=0, scan_in=0, busy=0, done=0, pass=0, signature=0 and counters at 0.
REQ-032 rst SHALL override abort and start, and SHALL abort a test mid-operation.

Structure
REQ-033 Shared package bist_pkg SHALL hold the state enum and the NORMAL, SHIFT and MISR mode encodings.
REQ-034 The phase counter SHALL be a sub-module named bist_counter, with load, decrement and zero-flag behaviour.

Verification
REQ-035 The bench SHALL cover a nominal run: CHAIN_LEN=4, num_cycles=3, start at edge 0 -> SEED in cycles 1-4, RUN in 5-7, UNLOAD in 8-11, done=1 in cycle 12 only, IDLE in cycle 13.
REQ-036 The bench SHALL cover seed shifting: seed=4'b0110 -> scan_in equals 0,1,1,0 in SEED cycles 1-4 with b1=0 and b2=1.
REQ-037 The bench SHALL cover signature capture: scan_out driven 1,0,1,1 in UNLOAD cycles and golden=4'b1101 -> signature=4'b1101 and pass=1; with golden=4'b1100 -> pass=0.
REQ-038 The bench SHALL cover a zero run length: num_cycles=0 -> SEED cycles 1-4, UNLOAD cycles 5-8, done in cycle 9, and b1 and b2 are never both 1.
REQ-039 The bench SHALL cover abort: abort in cycle 6 -> IDLE in cycle 7, done never asserted, pass=0, and a start in cycle 3 during the test is ignored.
REQ-040 The bench SHALL cover reset mid-test: rst asserted in cycle 9 -> all outputs at their REQ-031 values in cycle 10, and a new start after that completes normally.

Source files
------------

// File: rtl/bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bist_pkg                                                  |
// | Purpose  : Shared FSM state enum and BILBO mode encodings for the    |
// |            BIST controller.                                          |
// | Contents : state_t, mode_t, MODE_NORMAL/MODE_SHIFT/MODE_MISR,        |
// |            is_busy() helper.                                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // BILBO mode control pair. b2 is driven raw; the OR(b2, ~b1) term
  // lives outside this block.
  typedef struct packed {
    logic b1;
    logic b2;
  } mode_t;

  localparam mode_t MODE_NORMAL = 2'b10;
  localparam mode_t MODE_SHIFT  = 2'b01;
  localparam mode_t MODE_MISR   = 2'b11;

  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bist_ctrl_if                                              |
// | Purpose  : Bundle of the BIST controller request/response and scan   |
// |            chain control signals.                                    |
// | Modports : master - test requester / chain model side                |
// |            slave  - bist_ctrl side                                   |
// | Signals  : start, abort, seed, golden, num_cycles, scan_out (to      |
// |            controller); b1, b2, sel, scan_in, busy, done, pass,      |
// |            signature (from controller).                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface bist_ctrl_if #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic                 abort;
  logic [CHAIN_LEN-1:0] seed;
  logic [CHAIN_LEN-1:0] golden;
  logic [CNT_W-1:0]     num_cycles;
  logic                 scan_out;
  logic                 b1;
  logic                 b2;
  logic                 sel;
  logic                 scan_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] signature;

  modport master (
    output start, abort, seed, golden, num_cycles, scan_out,
    input  b1, b2, sel, scan_in, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, seed, golden, num_cycles, scan_out,
    output b1, b2, sel, scan_in, busy, done, pass, signature
  );
endinterface
`default_nettype wire

// File: rtl/bist_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bist_counter                                              |
// | Purpose  : Loadable down-counter timing each BIST phase. Holds at    |
// |            zero instead of wrapping.                                 |
// | Ports    : clk, rst      - clock, synchronous active-high reset      |
// |            load/load_val - reload (priority over dec)                |
// |            dec           - decrement when non-zero                   |
// |            zero          - count == 0                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bist_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_val,
  input  wire logic             dec,
  output      logic             zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bist_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bist_ctrl                                                 |
// | Purpose  : BILBO self-test sequencer: shifts a seed into the chain,  |
// |            runs MISR compaction for num_cycles, unloads the          |
// |            signature and compares it against a golden value.        |
// | Ports    : clk  - clock                                              |
// |            rst  - synchronous active-high reset                      |
// |            bus  - bist_ctrl_if.slave (start/abort/seed/golden/       |
// |                   num_cycles/scan_out in; b1/b2/sel/scan_in/busy/    |
// |                   done/pass/signature out)                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bist_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 16
) (
  input wire logic   clk,
  input wire logic   rst,
  bist_ctrl_if.slave bus
);

  import bist_pkg::*;

  // Each shift phase runs CHAIN_LEN cycles: the counter is loaded with
  // N-1 and the phase ends on the cycle where it reads zero.
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_cnt_load;
  logic [CNT_W-1:0]     w_cnt_load_val;
  logic                 w_cnt_dec;
  logic                 w_cnt_zero;
  logic                 w_accept;
  logic                 w_abort;

  logic [CHAIN_LEN-1:0] r_seed_sr;
  logic [CHAIN_LEN-1:0] r_golden;
  logic [CNT_W-1:0]     r_num;
  logic [CHAIN_LEN-1:0] r_signature;
  logic                 r_pass;
  logic [CHAIN_LEN-1:0] w_sig_next;

  mode_t                w_mode;
  logic                 w_sel;
  logic                 w_scan_in;
  logic                 w_done;

  bist_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  assign w_abort    = bus.abort && (r_state != ST_IDLE);
  assign w_sig_next = {bus.scan_out, r_signature[CHAIN_LEN-1:1]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    w_accept       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept       = 1'b1;
          w_next_state   = ST_SEED;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = LAST_SHIFT;
        end
      end
      ST_SEED: begin
        if (w_cnt_zero) begin
          w_cnt_load = 1'b1;
          // A zero run length skips MISR compaction entirely.
          if (r_num == '0) begin
            w_next_state   = ST_UNLOAD;
            w_cnt_load_val = LAST_SHIFT;
          end else begin
            w_next_state   = ST_RUN;
            w_cnt_load_val = r_num - CNT_W'(1);
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_cnt_zero) begin
          w_next_state   = ST_UNLOAD;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = LAST_SHIFT;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (w_cnt_zero) begin
          w_next_state = ST_DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the phase logic decided.
    if (w_abort) begin
      w_next_state   = ST_IDLE;
      w_cnt_load     = 1'b1;
      w_cnt_load_val = '0;
      w_cnt_dec      = 1'b0;
    end
  end

  // ------------------------------------------------------------ datapath
  // Seed/golden/run length are captured on the accepted start so that
  // the test is immune to later changes on the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed_sr   <= '0;
      r_golden    <= '0;
      r_num       <= '0;
      r_signature <= '0;
      r_pass      <= 1'b0;
    end else if (w_accept) begin
      r_seed_sr   <= bus.seed;
      r_golden    <= bus.golden;
      r_num       <= bus.num_cycles;
      r_signature <= '0;
      r_pass      <= 1'b0;
    end else if (w_abort) begin
      r_pass <= 1'b0;
    end else begin
      // Seed is consumed LSB first; shifting right keeps the next bit at [0].
      if (r_state == ST_SEED) begin
        r_seed_sr <= r_seed_sr >> 1;
      end
      if (r_state == ST_UNLOAD) begin
        r_signature <= w_sig_next;
        if (w_cnt_zero) begin
          r_pass <= (w_sig_next == r_golden);
        end
      end
    end
  end

  // ------------------------------------------------------ Moore outputs
  always_comb begin
    w_mode    = MODE_NORMAL;
    w_sel     = 1'b1;
    w_scan_in = 1'b0;
    w_done    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_sel = 1'b0;
      end
      ST_SEED: begin
        w_mode    = MODE_SHIFT;
        w_scan_in = r_seed_sr[0];
      end
      ST_RUN: begin
        w_mode = MODE_MISR;
      end
      ST_UNLOAD: begin
        w_mode = MODE_SHIFT;
      end
      ST_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_sel = 1'b0;
      end
    endcase
  end

  assign bus.b1        = w_mode.b1;
  assign bus.b2        = w_mode.b2;
  assign bus.sel       = w_sel;
  assign bus.scan_in   = w_scan_in;
  assign bus.busy      = is_busy(r_state);
  assign bus.done      = w_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_signature;

endmodule
`default_nettype wire

// File: tb/tb_bist_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bist_ctrl                                              |
// | Purpose  : Self-checking bench for bist_ctrl with CHAIN_LEN=4.       |
// |            Cycle k is the period after rising edge k-1, where edge 0 |
// |            is the one that samples start. Inputs are driven and      |
// |            outputs sampled on the falling edge.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_bist_ctrl;

  localparam int CL = 4;
  localparam int CW = 16;

  localparam int P_IDLE   = 0;
  localparam int P_SEED   = 1;
  localparam int P_RUN    = 2;
  localparam int P_UNLOAD = 3;
  localparam int P_DONE   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bist_ctrl_if #(.CHAIN_LEN(CL), .CNT_W(CW)) bif ();

  bist_ctrl #(
    .CHAIN_LEN (CL),
    .CNT_W     (CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected {b1,b2,sel,scan_in,busy,done}, one entry per cycle.
  logic [5:0] exp_q[$];

  function automatic logic [5:0] exp_vec(input int ph, input logic sbit);
    case (ph)
      P_SEED:   return {1'b0, 1'b1, 1'b1, sbit, 1'b1, 1'b0};
      P_RUN:    return {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      P_UNLOAD: return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      P_DONE:   return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      default:  return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  // Expected per-cycle outputs for cycles 1..ncyc of a test started at edge 0.
  task automatic push_schedule(input logic [CL-1:0] sd, input int num, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      if (c <= CL)                exp_q.push_back(exp_vec(P_SEED, sd[c-1]));
      else if (c <= CL + num)     exp_q.push_back(exp_vec(P_RUN, 1'b0));
      else if (c <= 2*CL + num)   exp_q.push_back(exp_vec(P_UNLOAD, 1'b0));
      else if (c == 2*CL + num + 1) exp_q.push_back(exp_vec(P_DONE, 1'b0));
      else                        exp_q.push_back(exp_vec(P_IDLE, 1'b0));
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    bif.start = 1'b0; bif.abort = 1'b0; bif.scan_out = 1'b0;
    bif.seed = '0; bif.golden = '0; bif.num_cycles = '0;
    repeat (3) @(negedge clk);
    obs = {bif.b1, bif.b2, bif.sel, bif.scan_in, bif.busy, bif.done};
    checks++;
    if (obs !== exp_vec(P_IDLE, 1'b0)) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs, exp_vec(P_IDLE, 1'b0));
    end
    checks++;
    if (bif.pass !== 1'b0) begin
      errors++; $display("FAIL reset_pass got %b want 0", bif.pass);
    end
    checks++;
    if (bif.signature !== '0) begin
      errors++; $display("FAIL reset_signature got %b want 0000", bif.signature);
    end
    rst = 1'b0;
  endtask

  // seed=0110, num_cycles=3, scan_out 1,0,1,1 in UNLOAD -> signature 1101.
  // With scramble set, seed/golden/num_cycles are changed during the test.
  task automatic test_nominal(input logic [CL-1:0] gd, input logic exp_pass, input bit scramble);
    logic [CL-1:0] sd = 4'b0110;
    logic [CL-1:0] so = 4'b1101;  // so[i] is driven in UNLOAD cycle i
    logic [5:0]    obs;
    logic [5:0]    exp;
    @(negedge clk);
    push_schedule(sd, 3, 13);
    bif.seed = sd; bif.golden = gd; bif.num_cycles = CW'(3); bif.start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (scramble && c >= 2) begin
        bif.seed = ~sd; bif.golden = ~gd; bif.num_cycles = CW'(5);
      end
      bif.scan_out = (c >= 8 && c <= 11) ? so[c-8] : 1'($urandom_range(1, 0));
      obs = {bif.b1, bif.b2, bif.sel, bif.scan_in, bif.busy, bif.done};
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL nominal_cycle%0d got %b want %b", c, obs, exp);
      end
      if (c == 12 || c == 13) begin
        checks++;
        if (bif.signature !== 4'b1101) begin
          errors++; $display("FAIL nominal_signature cycle%0d got %b want 1101", c, bif.signature);
        end
        checks++;
        if (bif.pass !== exp_pass) begin
          errors++; $display("FAIL nominal_pass cycle%0d got %b want %b", c, bif.pass, exp_pass);
        end
      end
    end
    bif.seed = sd; bif.golden = gd; bif.num_cycles = CW'(3);
  endtask

  // num_cycles=0: SEED 1-4, UNLOAD 5-8, DONE 9, IDLE 10.
  task automatic test_zero_len();
    logic [CL-1:0] sd = 4'b1001;
    logic [CL-1:0] so = 4'b0110;
    logic [5:0]    obs;
    logic [5:0]    exp;
    bit            both = 1'b0;
    @(negedge clk);
    push_schedule(sd, 0, 10);
    bif.seed = sd; bif.golden = 4'b0110; bif.num_cycles = '0; bif.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bif.start = 1'b0;
      bif.scan_out = (c >= 5 && c <= 8) ? so[c-5] : 1'b1;
      obs = {bif.b1, bif.b2, bif.sel, bif.scan_in, bif.busy, bif.done};
      if (bif.b1 === 1'b1 && bif.b2 === 1'b1) both = 1'b1;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL zero_len_cycle%0d got %b want %b", c, obs, exp);
      end
    end
    checks++;
    if (both) begin
      errors++; $display("FAIL zero_len_misr_seen got 1 want 0");
    end
    checks++;
    if (bif.signature !== 4'b0110 || bif.pass !== 1'b1) begin
      errors++; $display("FAIL zero_len_result got sig %b pass %b want sig 0110 pass 1", bif.signature, bif.pass);
    end
  endtask

  // Start again in cycle 3 (ignored), abort in cycle 6 -> IDLE in cycle 7.
  task automatic test_abort();
    logic [CL-1:0] sd = 4'b0011;
    logic [5:0]    obs;
    logic [5:0]    exp;
    @(negedge clk);
    push_schedule(sd, 3, 6);
    for (int c = 7; c <= 12; c++) exp_q.push_back(exp_vec(P_IDLE, 1'b0));
    bif.seed = sd; bif.golden = 4'b0000; bif.num_cycles = CW'(3); bif.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bif.start    = (c == 3);
      bif.abort    = (c == 6);
      bif.scan_out = 1'b0;
      obs = {bif.b1, bif.b2, bif.sel, bif.scan_in, bif.busy, bif.done};
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL abort_cycle%0d got %b want %b", c, obs, exp);
      end
      if (c == 7 || c == 12) begin
        checks++;
        if (bif.pass !== 1'b0) begin
          errors++; $display("FAIL abort_pass cycle%0d got %b want 0", c, bif.pass);
        end
      end
    end
    bif.abort = 1'b0;
  endtask

  // rst in cycle 9 (during UNLOAD) -> reset values in cycle 10, then a clean run.
  task automatic test_reset_mid();
    logic [CL-1:0] sd = 4'b1010;
    logic [5:0]    obs;
    logic [5:0]    exp;
    @(negedge clk);
    push_schedule(sd, 3, 9);
    bif.seed = sd; bif.golden = 4'b1111; bif.num_cycles = CW'(3); bif.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bif.start    = 1'b0;
      bif.scan_out = 1'b1;
      rst          = (c == 9);
      bif.abort    = (c == 9);
      obs = {bif.b1, bif.b2, bif.sel, bif.scan_in, bif.busy, bif.done};
      if (c <= 9) begin
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL reset_mid_cycle%0d got %b want %b", c, obs, exp);
        end
      end else begin
        checks++;
        if (obs !== exp_vec(P_IDLE, 1'b0)) begin
          errors++; $display("FAIL reset_mid_outputs got %b want %b", obs, exp_vec(P_IDLE, 1'b0));
        end
        checks++;
        if (bif.signature !== '0 || bif.pass !== 1'b0) begin
          errors++; $display("FAIL reset_mid_state got sig %b pass %b want sig 0000 pass 0", bif.signature, bif.pass);
        end
      end
    end
    rst = 1'b0;
    bif.abort = 1'b0;
    test_nominal(4'b1101, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal(4'b1101, 1'b1, 1'b1);
    test_nominal(4'b1100, 1'b0, 1'b0);
    test_zero_len();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
